sdf_twiddle_mult: RTL and testbench

- Complex twiddle-factor multiplier placed directly downstream of each radix-2 single-path delay-feedback butterfly stage of the pipelined FFT.
- Counts samples within the stage frame and looks up W_N^k from an internal ROM.
- Multiplies the butterfly output by that twiddle, then rounds and saturates back to the data width for the next butterfly.
- Trivial twiddles (1 and -j) take exact bypass paths, so those samples incur no quantisation error.

---
 rtl/sdf_twiddle_mult.sv | 187 ++++++++++++++++++
 tb/tb_sdf_twiddle_mult.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdf_twiddle_mult.sv
// Twiddle multiplier that follows a radix-2 SDF butterfly stage. It tracks the sample index
// within the frame, looks up W_N^k, and returns a rounded, saturated complex product.
module sdf_twiddle_mult #(
  parameter int DW = 14,
  parameter int TW = 12,
  parameter int N  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic                 frame_sync,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  output logic                 valid_out,
  output logic signed [DW-1:0] out_re,
  output logic signed [DW-1:0] out_im
);

  localparam int  KW   = $clog2(N);
  localparam int  MW   = KW - 1;
  localparam int  HALF = N / 2;
  localparam int  QTR  = N / 4;
  localparam int  PW   = DW + TW;
  localparam int  SW   = PW + 1;
  localparam int  FS   = 2**(TW-1) - 1;
  localparam real PI   = 3.14159265358979323846;

  localparam logic signed [SW-1:0] RND    = SW'(2**(TW-2));
  localparam logic signed [SW-1:0] SAT_HI = SW'(2**(DW-1) - 1);
  localparam logic signed [SW-1:0] SAT_LO = SW'(-(2**(DW-1)));

  typedef enum logic [1:0] {
    CLS_ID  = 2'd0,
    CLS_MJ  = 2'd1,
    CLS_GEN = 2'd2
  } cls_t;

  // Elaboration-time trig, evaluated as Taylor series so no math library is needed.
  function automatic real cos_f(input real x);
    real term;
    real sum;
    term = 1.0;
    sum  = 1.0;
    for (int i = 1; i < 14; i++) begin
      term = -term * x * x / (real'(2*i-1) * real'(2*i));
      sum  = sum + term;
    end
    return sum;
  endfunction

  function automatic real sin_f(input real x);
    real term;
    real sum;
    term = x;
    sum  = x;
    for (int i = 1; i < 14; i++) begin
      term = -term * x * x / (real'(2*i) * real'(2*i+1));
      sum  = sum + term;
    end
    return sum;
  endfunction

  function automatic int round_f(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    else          return -$rtoi(0.5 - v);
  endfunction

  function automatic logic signed [DW-1:0] sat_f(input logic signed [SW-1:0] x);
    if (x > SAT_HI)      return SAT_HI[DW-1:0];
    else if (x < SAT_LO) return SAT_LO[DW-1:0];
    else                 return x[DW-1:0];
  endfunction

  logic signed [TW-1:0] rom_cos [HALF];
  logic signed [TW-1:0] rom_sin [HALF];

  for (genvar g = 0; g < HALF; g++) begin : g_rom
    localparam real ANG = 2.0 * PI * real'(g) / real'(N);
    localparam int  CV  = round_f(real'(FS) * cos_f(ANG));
    localparam int  SV  = round_f(real'(FS) * sin_f(ANG));
    assign rom_cos[g] = TW'(CV);
    assign rom_sin[g] = TW'(SV);
  end

  // Sample index and twiddle class for the sample currently at the input
  logic [KW-1:0] k_q, k_d, k_cur;
  logic [MW-1:0] m_idx;
  cls_t          cls_cur;

  always_comb begin
    k_cur   = (valid_in && frame_sync) ? '0 : k_q;
    k_d     = valid_in ? k_cur + KW'(1) : k_q;
    m_idx   = k_cur[MW-1:0];
    cls_cur = CLS_GEN;
    if (!k_cur[KW-1] || (m_idx == '0)) cls_cur = CLS_ID;
    else if (m_idx == MW'(QTR))        cls_cur = CLS_MJ;
  end

  // Stage 1: input, class and coefficient registers
  logic                 v1_q;
  logic signed [DW-1:0] re1_q, im1_q;
  logic signed [TW-1:0] c1_q, s1_q;
  cls_t                 cls1_q;

  // Stage 2: partial products
  logic                 v2_q;
  logic signed [DW-1:0] re2_q, im2_q;
  cls_t                 cls2_q;
  logic signed [PW-1:0] p_rc_q, p_is_q, p_ic_q, p_rs_q;
  logic signed [PW-1:0] p_rc_d, p_is_d, p_ic_d, p_rs_d;

  always_comb begin
    p_rc_d = PW'(re1_q) * PW'(c1_q);
    p_is_d = PW'(im1_q) * PW'(s1_q);
    p_ic_d = PW'(im1_q) * PW'(c1_q);
    p_rs_d = PW'(re1_q) * PW'(s1_q);
  end

  // Stage 3: sum, round half-up, saturate
  logic                 v3_q;
  logic signed [DW-1:0] out_re_q, out_im_q, out_re_d, out_im_d;
  logic signed [SW-1:0] sum_re, sum_im, rnd_re, rnd_im;

  always_comb begin
    sum_re   = SW'(p_rc_q) + SW'(p_is_q);
    sum_im   = SW'(p_ic_q) - SW'(p_rs_q);
    rnd_re   = (sum_re + RND) >>> (TW-1);
    rnd_im   = (sum_im + RND) >>> (TW-1);
    out_re_d = out_re_q;
    out_im_d = out_im_q;
    if (v2_q) begin
      case (cls2_q)
        CLS_ID: begin
          out_re_d = re2_q;
          out_im_d = im2_q;
        end
        CLS_MJ: begin
          out_re_d = im2_q;
          out_im_d = sat_f(-SW'(re2_q));
        end
        default: begin
          out_re_d = sat_f(rnd_re);
          out_im_d = sat_f(rnd_im);
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q      <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      out_re_q <= '0;
      out_im_q <= '0;
    end else begin
      k_q      <= k_d;
      v1_q     <= valid_in;
      v2_q     <= v1_q;
      v3_q     <= v2_q;
      out_re_q <= out_re_d;
      out_im_q <= out_im_d;
    end
  end

  // Datapath registers are qualified by the valid chain and need no reset
  always_ff @(posedge clk) begin
    re1_q  <= in_re;
    im1_q  <= in_im;
    cls1_q <= cls_cur;
    c1_q   <= rom_cos[m_idx];
    s1_q   <= rom_sin[m_idx];
    re2_q  <= re1_q;
    im2_q  <= im1_q;
    cls2_q <= cls1_q;
    p_rc_q <= p_rc_d;
    p_is_q <= p_is_d;
    p_ic_q <= p_ic_d;
    p_rs_q <= p_rs_d;
  end

  assign valid_out = v3_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;

endmodule

// File: tb/tb_sdf_twiddle_mult.sv
// Bench for sdf_twiddle_mult: a table of twiddle vectors, directed sequences, and a random
// phase, all checked every cycle against a delay-line reference built from trig and plain arithmetic.
module tb_sdf_twiddle_mult;
  localparam int  DW = 14;
  localparam int  TW = 12;
  localparam int  N  = 16;
  localparam int  FS = 2**(TW-1) - 1;
  localparam real PI = 3.14159265358979323846;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 valid_in = 1'b0;
  logic                 frame_sync = 1'b0;
  logic signed [DW-1:0] in_re = '0;
  logic signed [DW-1:0] in_im = '0;
  logic                 valid_out;
  logic signed [DW-1:0] out_re;
  logic signed [DW-1:0] out_im;

  sdf_twiddle_mult #(.DW(DW), .TW(TW), .N(N)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .frame_sync(frame_sync),
    .in_re(in_re), .in_im(in_im),
    .valid_out(valid_out), .out_re(out_re), .out_im(out_im)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: frame index, two in-flight samples, and the held output
  int kk = 0;
  bit pv [2] = '{0, 0};
  int pre [2] = '{0, 0};
  int pim [2] = '{0, 0};
  bit exp_v = 0;
  int exp_re = 0;
  int exp_im = 0;

  int last_re = 0;
  int last_im = 0;
  int vcount = 0;

  typedef struct {
    int k;
    int re;
    int im;
    int ere;
    int eim;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int sat(input longint x);
    if (x > 2**(DW-1) - 1) return 2**(DW-1) - 1;
    if (x < -(2**(DW-1)))  return -(2**(DW-1));
    return int'(x);
  endfunction

  function automatic int rnd(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(0.5 - v);
  endfunction

  task automatic ref_model(input int idx, input int re, input int im, output int ore, output int oim);
    int m;
    longint c, s, sr, si;
    if (idx <= N/2) begin
      ore = re;
      oim = im;
    end else begin
      m = idx - N/2;
      if (m == N/4) begin
        ore = im;
        oim = sat(-longint'(re));
      end else begin
        c  = rnd(real'(FS) * $cos(2.0 * PI * real'(m) / real'(N)));
        s  = rnd(real'(FS) * $sin(2.0 * PI * real'(m) / real'(N)));
        sr = longint'(re) * c + longint'(im) * s;
        si = longint'(im) * c - longint'(re) * s;
        ore = sat((sr + 2**(TW-2)) >>> (TW-1));
        oim = sat((si + 2**(TW-2)) >>> (TW-1));
      end
    end
  endtask

  // Drive one cycle at the falling edge, advance the reference at the rising edge,
  // then compare at the next falling edge.
  task automatic cycle(input bit r, input bit v, input bit fs, input int re, input int im);
    int idx, ore, oim;
    rst = r;
    valid_in = v;
    frame_sync = fs;
    in_re = DW'(re);
    in_im = DW'(im);
    @(posedge clk);
    if (r) begin
      kk = 0;
      pv = '{0, 0};
      exp_v = 0;
      exp_re = 0;
      exp_im = 0;
    end else begin
      exp_v = pv[1];
      if (pv[1]) begin
        exp_re = pre[1];
        exp_im = pim[1];
      end
      pv[1] = pv[0];
      pre[1] = pre[0];
      pim[1] = pim[0];
      pv[0] = v;
      if (v) begin
        idx = fs ? 0 : kk;
        kk = (idx + 1) % N;
        ref_model(idx, re, im, ore, oim);
        pre[0] = ore;
        pim[0] = oim;
      end
    end
    @(negedge clk);
    chk("valid_out", int'(valid_out), int'(exp_v));
    chk("out_re", int'(out_re), exp_re);
    chk("out_im", int'(out_im), exp_im);
    if (valid_out === 1'b1) begin
      last_re = int'(out_re);
      last_im = int'(out_im);
      vcount++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  function automatic int rdata();
    case ($urandom_range(0, 7))
      0:       return -(2**(DW-1));
      1:       return 2**(DW-1) - 1;
      default: return int'($urandom_range(0, 2**DW - 1)) - 2**(DW-1);
    endcase
  endfunction

  initial begin
    // Hand-derived twiddle results: k, in, expected out (cos/sin ROM 1891/783/1447)
    tbl[0] = '{k: 10, re: 1000,  im: 0,     ere: 707,   eim: -707};
    tbl[1] = '{k: 12, re: -8192, im: 300,   ere: 300,   eim: 8191};
    tbl[2] = '{k: 3,  re: -8192, im: 8191,  ere: -8192, eim: 8191};
    tbl[3] = '{k: 8,  re: 1234,  im: -4321, ere: 1234,  eim: -4321};
    tbl[4] = '{k: 12, re: 5000,  im: -8192, ere: -8192, eim: -5000};
    tbl[5] = '{k: 9,  re: 2048,  im: 0,     ere: 1891,  eim: -783};
    tbl[6] = '{k: 10, re: 8191,  im: 8191,  ere: 8191,  eim: 0};
    tbl[7] = '{k: 10, re: -8192, im: -8192, ere: -8192, eim: 0};
    tbl[8] = '{k: 15, re: 0,     im: 2048,  ere: 783,   eim: -1891};

    @(negedge clk);

    // Reset then idle
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    vcount = 0;
    idle(5);
    chk("idle_no_valid", vcount, 0);

    // Identity half
    vcount = 0;
    for (int k = 0; k < 8; k++) cycle(0, 1, k == 0, k * 100, -k * 100);
    idle(4);
    chk("identity_count", vcount, 8);
    chk("identity_last_re", last_re, 700);
    chk("identity_last_im", last_im, -700);

    // Table-driven twiddle vectors
    foreach (tbl[i]) begin
      for (int idx = 0; idx <= tbl[i].k; idx++)
        cycle(0, 1, idx == 0, (idx == tbl[i].k) ? tbl[i].re : 0, (idx == tbl[i].k) ? tbl[i].im : 0);
      idle(3);
      chk($sformatf("vec%0d_re", i), last_re, tbl[i].ere);
      chk($sformatf("vec%0d_im", i), last_im, tbl[i].eim);
    end

    // Frame sync at k=5 with gaps; the sample 10 after the sync must see W(m=2)
    for (int idx = 0; idx < 5; idx++) begin
      cycle(0, 1, idx == 0, rdata(), rdata());
      if ($urandom_range(0, 1) == 1) cycle(0, 0, 1, 0, 0);
    end
    for (int idx = 0; idx <= 10; idx++) begin
      cycle(0, 1, idx == 0, (idx == 10) ? 1000 : rdata(), (idx == 10) ? 0 : rdata());
      if ($urandom_range(0, 2) == 0) cycle(0, 0, 0, 0, 0);
    end
    idle(3);
    chk("resync_re", last_re, 707);
    chk("resync_im", last_im, -707);

    // Reset mid-frame with samples in flight
    for (int idx = 0; idx < 9; idx++) cycle(0, 1, idx == 0, rdata(), rdata());
    cycle(1, 1, 0, 1000, 0);
    vcount = 0;
    cycle(1, 0, 0, 0, 0);
    idle(3);
    chk("flush_no_valid", vcount, 0);
    cycle(0, 1, 0, 500, -600);
    idle(3);
    chk("post_reset_re", last_re, 500);
    chk("post_reset_im", last_im, -600);

    // Random traffic
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0, rdata(), rdata());
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
